// File: rtl/arb_xfer_ctrl.sv
// rtl/arb_xfer_ctrl.sv - burst transfer controller behind a 4-way round-robin arbiter (optional stall abort: ARB_XFER_TIMEOUT_EN)
module arb_xfer_ctrl #(
    parameter int DATA_W         = 8,
    parameter int LEN_W          = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [3:0]          grant,
    output logic                arb_ack,
    input  logic [3:0]          src_valid,
    input  logic [4*DATA_W-1:0] src_data,
    input  logic [4*LEN_W-1:0]  src_len,
    output logic [3:0]          src_ready,
    output logic                dst_valid,
    output logic [DATA_W-1:0]   dst_data,
    input  logic                dst_ready,
    output logic                dst_last,
    output logic [1:0]          dst_owner,
`ifdef ARB_XFER_TIMEOUT_EN
    output logic                busy,
    output logic                timeout_err
`else
    output logic                busy
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               beat;

`ifdef ARB_XFER_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               tmo_q, tmo_d;
`endif

    // Lowest set bit wins when the arbiter ever presents more than one grant bit
    function automatic logic [1:0] low_idx(input logic [3:0] g);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (g[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // State, ownership and beat bookkeeping registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= 2'd0;
            len_q   <= '0;
            cnt_q   <= '0;
`ifdef ARB_XFER_TIMEOUT_EN
            stall_q <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
`ifdef ARB_XFER_TIMEOUT_EN
            stall_q <= stall_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Next-state logic and the owner's combinational pass-through datapath
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        arb_ack   = 1'b0;
        src_ready = 4'b0000;
        dst_valid = 1'b0;
        dst_data  = '0;
        dst_last  = 1'b0;
        beat      = 1'b0;
`ifdef ARB_XFER_TIMEOUT_EN
        stall_d   = stall_q;
        tmo_d     = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    owner_d = low_idx(grant);
                    len_d   = src_len[owner_d*LEN_W +: LEN_W];
                    cnt_d   = '0;
                    state_d = ST_XFER;
`ifdef ARB_XFER_TIMEOUT_EN
                    stall_d = '0;
`endif
                end
            end
            ST_XFER: begin
                dst_valid          = src_valid[owner_q];
                dst_data           = src_data[owner_q*DATA_W +: DATA_W];
                src_ready[owner_q] = dst_ready;
                dst_last           = (cnt_q == len_q);
                beat               = dst_valid && dst_ready;
                if (beat) begin
                    // The final beat leaves the state, so the count never wraps
                    if (dst_last) state_d = ST_RELEASE;
                    else          cnt_d   = cnt_q + LEN_W'(1);
`ifdef ARB_XFER_TIMEOUT_EN
                    stall_d = '0;
`endif
                end
`ifdef ARB_XFER_TIMEOUT_EN
                else if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                    // Abort the stalled burst; the arbiter still gets its ack
                    state_d = ST_RELEASE;
                    tmo_d   = 1'b1;
                    stall_d = '0;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
`endif
            end
            ST_RELEASE: begin
                arb_ack = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs derived from registered state
    always_comb begin
        busy      = (state_q != ST_IDLE);
        dst_owner = owner_q;
`ifdef ARB_XFER_TIMEOUT_EN
        timeout_err = tmo_q;
`endif
    end

endmodule

// File: tb/tb_arb_xfer_ctrl.sv
// tb/tb_arb_xfer_ctrl.sv - randomized self-checking bench for arb_xfer_ctrl against a beats-remaining model
module tb_arb_xfer_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  grant;
    logic        arb_ack;
    logic [3:0]  src_valid;
    logic [31:0] src_data;
    logic [7:0]  src_len;
    logic [3:0]  src_ready;
    logic        dst_valid;
    logic [7:0]  dst_data;
    logic        dst_ready;
    logic        dst_last;
    logic [1:0]  dst_owner;
    logic        busy;
`ifdef ARB_XFER_TIMEOUT_EN
    logic        timeout_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a burst is "active" with some beats left, then owes one ack cycle
    bit          m_active;
    bit          m_ack_due;
    int          m_owner;
    int          m_left;

    arb_xfer_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .grant     (grant),
        .arb_ack   (arb_ack),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_len   (src_len),
        .src_ready (src_ready),
        .dst_valid (dst_valid),
        .dst_data  (dst_data),
        .dst_ready (dst_ready),
        .dst_last  (dst_last),
        .dst_owner (dst_owner),
`ifdef ARB_XFER_TIMEOUT_EN
        .busy      (busy),
        .timeout_err (timeout_err)
`else
        .busy      (busy)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model at the edge
    task automatic step(input logic rst, input logic [3:0] g, input logic [3:0] sv,
                        input logic [31:0] sd, input logic [7:0] sl, input logic dr);
        logic [3:0] e_rdy;
        logic [7:0] e_data;
        reset     = rst;
        grant     = g;
        src_valid = sv;
        src_data  = sd;
        src_len   = sl;
        dst_ready = dr;
        #3;
        chk("arb_ack", 32'(arb_ack), 32'(m_ack_due));
        chk("busy", 32'(busy), 32'(m_active || m_ack_due));
        chk("dst_owner", 32'(dst_owner), 32'(m_owner));
        if (m_active) begin
            e_rdy  = 4'b0000;
            e_rdy[m_owner] = dr;
            e_data = sd[m_owner*8 +: 8];
            chk("dst_valid", 32'(dst_valid), 32'(sv[m_owner]));
            chk("src_ready", 32'(src_ready), 32'(e_rdy));
            chk("dst_last", 32'(dst_last), 32'(m_left == 1));
            chk("dst_data", 32'(dst_data), 32'(e_data));
        end else begin
            chk("dst_valid_idle", 32'(dst_valid), 32'd0);
            chk("src_ready_idle", 32'(src_ready), 32'd0);
            chk("dst_last_idle", 32'(dst_last), 32'd0);
        end
        @(posedge clock);
        if (rst) begin
            m_active = 0; m_ack_due = 0; m_owner = 0; m_left = 0;
        end else if (m_ack_due) begin
            m_ack_due = 0;
        end else if (m_active) begin
            if (sv[m_owner] && dr) begin
                m_left--;
                if (m_left == 0) begin
                    m_active  = 0;
                    m_ack_due = 1;
                end
            end
        end else if (g != 4'b0000) begin
            m_owner = 0;
            while (!g[m_owner]) m_owner++;
            m_left   = int'(sl[m_owner*2 +: 2]) + 1;
            m_active = 1;
        end
        #1;
    endtask

    initial begin
        int tok;
        int acks;
        logic [3:0] g;
        logic [3:0] sv;
        logic       rst;

        m_active = 0; m_ack_due = 0; m_owner = 0; m_left = 0;
        reset = 1'b1; grant = '0; src_valid = '0; src_data = '0; src_len = '0; dst_ready = 1'b0;
        @(posedge clock);
        #1;
        step(1'b1, 4'b0000, 4'b0000, 32'h0, 8'h00, 1'b0);

        // Single requester, len=3, continuous flow
        step(1'b0, 4'b0001, 4'b0001, 32'h0000_00a1, 8'h03, 1'b1);
        for (int i = 0; i < 4; i++)
            step(1'b0, 4'b0000, 4'b0001, 32'h0000_00b0 + 32'(i), 8'h00, 1'b1);
        step(1'b0, 4'b0000, 4'b0001, 32'h0, 8'h00, 1'b1);
        step(1'b0, 4'b0000, 4'b0000, 32'h0, 8'h00, 1'b1);

        // Round-robin with len=0 on all four: the arbiter moves only on ack
        tok  = 0;
        acks = 0;
        for (int i = 0; i < 15; i++) begin
            if (m_ack_due) acks++;
            step(1'b0, 4'(1 << tok), 4'b1111, 32'h4433_2211, 8'h00, 1'b1);
            if (arb_ack === 1'b1) tok = (tok + 1) % 4;
        end
        chk("rr_acks", 32'(acks), 32'd5);

        // Backpressure on owner 2, len=1
        step(1'b0, 4'b0100, 4'b0100, 32'h00c3_0000, 8'h10, 1'b0);
        step(1'b0, 4'b0000, 4'b0100, 32'h00c4_0000, 8'h00, 1'b1);
        step(1'b0, 4'b0000, 4'b0100, 32'h00c5_0000, 8'h00, 1'b0);
        step(1'b0, 4'b0000, 4'b0100, 32'h00c6_0000, 8'h00, 1'b0);
        step(1'b0, 4'b0000, 4'b0100, 32'h00c7_0000, 8'h00, 1'b1);
        step(1'b0, 4'b0000, 4'b0000, 32'h0, 8'h00, 1'b1);

        // Grant change mid-burst, owner 1 len=3
        step(1'b0, 4'b0010, 4'b0010, 32'h0, 8'h0c, 1'b1);
        step(1'b0, 4'b0010, 4'b0010, 32'h0000_d100, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++)
            step(1'b0, 4'b0100, 4'b0110, 32'h0000_d200 + 32'(i << 8), 8'hff, 1'b1);

        // Reset mid-burst, owner 3 len=3
        step(1'b0, 4'b0000, 4'b0000, 32'h0, 8'h00, 1'b1);
        step(1'b0, 4'b1000, 4'b1000, 32'h0, 8'hc0, 1'b1);
        step(1'b0, 4'b0000, 4'b1000, 32'he100_0000, 8'h00, 1'b1);
        step(1'b0, 4'b0000, 4'b1000, 32'he200_0000, 8'h00, 1'b1);
        step(1'b1, 4'b0000, 4'b1000, 32'he300_0000, 8'h00, 1'b1);
        step(1'b0, 4'b0000, 4'b0000, 32'h0, 8'h00, 1'b1);

        // Randomized traffic: sparse reset, mixed grant shapes, random stalls
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            case ($urandom_range(0, 3))
                0:       g = 4'b0000;
                1, 2:    g = 4'(1 << $urandom_range(0, 3));
                default: g = 4'($urandom);
            endcase
            sv = 4'($urandom) | 4'($urandom);
            step(rst, g, sv, $urandom, 8'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arb_xfer_ctrl.md
Name: arb_xfer_ctrl

Overview:
- Transfer controller directly downstream of the 4-way round-robin arbiter.
- Consumes the arbiter's one-hot grant and locks ownership to the granted requester for a whole burst.
- Muxes that requester's valid/data beats onto a single target port.
- Returns a one-cycle ack to the arbiter's token-advance input when the burst completes, so the next requester is served.

Parameters:
- DATA_W, 8, width of one data beat.
- LEN_W, 2, width of the per-requester burst-length field; burst beats = len+1, giving 1..2^LEN_W.
- TIMEOUT_CYCLES, 16, stall limit in cycles; used only when the optional feature is compiled in.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- grant  in  4  one-hot grant from the arbiter; combinational on the arbiter side.
- arb_ack  out  1  one-cycle pulse to the arbiter's ack/enable input; advances its token.
- src_valid  in  4  per-requester beat valid.
- src_data  in  4*DATA_W  per-requester beat data; requester i occupies bits [i*DATA_W +: DATA_W].
- src_len  in  4*LEN_W  per-requester burst length minus one; sampled only at lock.
- src_ready  out  4  per-requester beat accept.
- dst_valid  out  1  beat valid to target.
- dst_data  out  DATA_W  beat data to target.
- dst_ready  in  1  target accepts beat.
- dst_last  out  1  current beat is the final beat of the burst.
- dst_owner  out  2  index of the current owner.
- busy  out  1  high in XFER and RELEASE.
- timeout_err  out  1  sticky stall-abort flag; present only with the optional feature.

Behaviour:
- FSM states: IDLE, XFER, RELEASE. Encoding is free.
- Reset (synchronous, active-high):
  - State goes to IDLE; owner=0; beat count=0; captured len=0.
  - arb_ack=0, busy=0, dst_valid=0, dst_last=0, src_ready=4'b0000, dst_owner=0, timeout_err=0.
  - No ack is issued on reset, including reset asserted mid-burst; a partial burst is simply dropped.
- IDLE:
  - Outputs: src_ready=0, dst_valid=0.
  - grant==0: stay in IDLE.
  - grant!=0: register owner = index of grant; if more than one bit is set, take the lowest set bit. Also register len = src_len[owner], clear the beat count, and go to XFER.
  - Lock latency is 1 cycle from grant to the first beat being eligible.
- XFER:
  - Datapath is combinational pass-through, zero added latency:
    - dst_valid = src_valid[owner]; dst_data = src_data[owner].
    - src_ready[owner] = dst_ready; all other src_ready bits are 0.
  - A beat completes on dst_valid && dst_ready; the count increments by 1.
  - dst_last = (count == len).
  - Grant changes and src_len changes during XFER are ignored; ownership holds until the burst ends.
  - On a beat with count==len, go to RELEASE. The count does not wrap; the last beat exits the state.
  - A stall (src_valid low or dst_ready low) holds state indefinitely, unless the optional feature is compiled in.
- RELEASE:
  - arb_ack=1 for exactly this one cycle; src_ready=0; dst_valid=0; next state is IDLE.
  - The arbiter token advances on this edge, so grant is re-sampled in IDLE on the following cycle.
  - Back-to-back burst overhead is therefore 2 idle cycles (RELEASE + IDLE lock).
- dst_owner shows the registered owner at all times; it holds its last value in IDLE.
- busy = (state != IDLE).
- Boundaries:
  - len=0 is a single-beat burst; dst_last is high on the first beat.
  - len=2^LEN_W-1 is the maximum burst; the counter must not overflow before exit.
  - Requester dropping src_valid mid-burst: the burst pauses, with no abort.
  - grant deasserting in the IDLE cycle: no lock.

Optional Feature:
- Macro: ARB_XFER_TIMEOUT_EN.
- Defined:
  - A stall counter counts consecutive XFER cycles with no completed beat. It resets on every completed beat and on entry to XFER.
  - When the count reaches TIMEOUT_CYCLES, abort: go to RELEASE (arb_ack pulses normally) and set timeout_err=1.
  - timeout_err stays high until reset.
- Undefined:
  - No stall counter exists and the timeout_err port is absent.
  - XFER waits forever.

Test Plan:
- Single requester: req0 with len=3, dst_ready=1, src_valid0=1 continuously, grant=0001 → lock next cycle; 4 beats on consecutive cycles with dst_owner=0; dst_last on beat 4; arb_ack pulses the cycle after beat 4.
- All 4 requesting with len=0, arbiter in loop → owners served 0,1,2,3,0; each burst takes 3 cycles (IDLE, XFER, RELEASE); exactly one arb_ack per burst.
- Backpressure: owner 2, len=1, dst_ready toggling 1,0,0,1 → exactly 2 beats accepted, src_ready[2] mirrors dst_ready, other src_ready bits stay 0, dst_data matches src_data[2] on each accepted beat.
- Grant change mid-burst: lock owner 1 with len=3; after beat 1, grant switches to 0100 → owner stays 1 until beat 4 completes; no early arb_ack.
- Reset mid-burst: owner 3, len=3, reset asserted after 2 beats → next cycle IDLE, busy=0, src_ready=0, no arb_ack pulse.
- With ARB_XFER_TIMEOUT_EN, TIMEOUT_CYCLES=16: owner 0 locked, src_valid0=0 → on stall cycle 16, RELEASE, arb_ack=1, timeout_err=1, which stays set until reset.
